// File: rtl/mmio_bridge.sv
// CPU-side MMIO bridge: routes bus accesses to data RAM or the peripheral page and
// owns the LED, switch/button synchronizers, seven-segment scanner and timer.
module mmio_bridge #(
  parameter int SCAN_DIV  = 20000,
  parameter int TIMER_DIV = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] Bus_addr,
  input  logic        Bus_wen,
  input  logic [31:0] Bus_wdata,
  output logic [31:0] Bus_rdata,
  output logic [13:0] dram_addr,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  button,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam logic [31:0] SCAN_LAST  = 32'(SCAN_DIV - 1);
  localparam logic [31:0] TIMER_LAST = 32'(TIMER_DIV - 1);

  // Word offsets within the peripheral page (byte offset >> 2).
  localparam logic [9:0] OFF_DIGITS = 10'h000;
  localparam logic [9:0] OFF_TIMER  = 10'h008;
  localparam logic [9:0] OFF_LED    = 10'h018;
  localparam logic [9:0] OFF_SW     = 10'h01C;
  localparam logic [9:0] OFF_BTN    = 10'h01E;

  function automatic logic [7:0] hex7seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  logic        page_hit;
  logic [9:0]  off;
  logic        per_wen;
  logic        unused_addr_bits;

  logic [31:0] digits;
  logic [31:0] timer;
  logic [31:0] presc;
  logic [23:0] led_reg;
  logic [23:0] sw_s1, sw_s2;
  logic [4:0]  btn_s1, btn_s2;
  logic [31:0] scan_cnt;
  logic [2:0]  idx;

  logic        scan_done;
  logic [2:0]  idx_next;
  logic [31:0] digits_next;
  logic [3:0]  nibble;
  logic [31:0] rdata_per;

  assign page_hit         = (Bus_addr[31:12] == 20'hFFFFF);
  assign off              = Bus_addr[11:2];
  assign per_wen          = Bus_wen & page_hit;
  assign unused_addr_bits = ^Bus_addr[1:0];

  assign dram_addr  = Bus_addr[15:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen & ~page_hit & cpu_rst;
  assign led        = led_reg;

  // seg/dig_en are registered from next-state values so a DIGITS store shows up right after its edge.
  always_comb begin
    scan_done   = (scan_cnt == SCAN_LAST);
    idx_next    = scan_done ? idx + 3'd1 : idx;
    digits_next = (per_wen && off == OFF_DIGITS) ? Bus_wdata : digits;
    nibble      = digits_next[{idx_next, 2'b00} +: 4];
  end

  always_comb begin
    rdata_per = '0;
    case (off)
      OFF_DIGITS: rdata_per = digits;
      OFF_TIMER:  rdata_per = timer;
      OFF_LED:    rdata_per = {8'h00, led_reg};
      OFF_SW:     rdata_per = {8'h00, sw_s2};
      OFF_BTN:    rdata_per = {27'h0, btn_s2};
      default:    rdata_per = '0;
    endcase
    Bus_rdata = page_hit ? rdata_per : dram_rdata;
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      digits   <= '0;
      led_reg  <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      btn_s1   <= '0;
      btn_s2   <= '0;
      scan_cnt <= '0;
      idx      <= '0;
      dig_en   <= 8'hFE;
      seg      <= 8'hC0;
    end else begin
      digits   <= digits_next;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      btn_s1   <= button;
      btn_s2   <= btn_s1;
      scan_cnt <= scan_done ? 32'd0 : scan_cnt + 32'd1;
      idx      <= idx_next;
      dig_en   <= ~(8'b1 << idx_next);
      seg      <= hex7seg(nibble);
      if (per_wen && off == OFF_LED)
        led_reg <= Bus_wdata[23:0];
    end
  end

  // A TIMER store overrides a coincident increment and restarts the prescaler.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      timer <= '0;
      presc <= '0;
    end else if (per_wen && off == OFF_TIMER) begin
      timer <= Bus_wdata;
      presc <= '0;
    end else if (presc == TIMER_LAST) begin
      timer <= timer + 32'd1;
      presc <= '0;
    end else begin
      presc <= presc + 32'd1;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: expected values are queued when stimulus is
// driven and popped when the corresponding output is sampled.
module tb_mmio_bridge;

  logic        cpu_clk;
  logic        cpu_rst;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw;
  logic [4:0]  button;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [15:0] scan_q[$];
  logic [31:0] ram [0:255];

  mmio_bridge #(.SCAN_DIV(4), .TIMER_DIV(2)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata),
    .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .sw(sw), .button(button), .led(led), .dig_en(dig_en), .seg(seg)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) if (dram_wen) ram[dram_addr[7:0]] <= dram_wdata;
  assign dram_rdata = ram[dram_addr[7:0]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Bus_addr = addr; Bus_wdata = data; Bus_wen = 1'b1;
    @(posedge cpu_clk); #1;
    Bus_wen = 1'b0;
  endtask

  task automatic set_read(input logic [31:0] addr, input logic [31:0] expv);
    Bus_addr = addr; Bus_wen = 1'b0;
    exp_q.push_back(expv);
    #1;
  endtask

  task automatic check_read(input string name);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_tests++;
    if (Bus_rdata !== e) begin
      n_fail++;
      $display("FAIL %s: Bus_rdata got %h expected %h", name, Bus_rdata, e);
    end
  endtask

  task automatic test_reset;
    cpu_rst = 1'b0; Bus_addr = 32'h40; Bus_wen = 1'b1; Bus_wdata = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (dram_wen !== 1'b0) begin n_fail++; $display("FAIL reset_dram_wen: got %b expected 0", dram_wen); end
    repeat (2) @(posedge cpu_clk);
    #1;
    Bus_wen = 1'b0;
    n_tests++;
    if (led !== 24'h0) begin n_fail++; $display("FAIL reset_led: got %h expected 000000", led); end
    n_tests++;
    if (dig_en !== 8'hFE) begin n_fail++; $display("FAIL reset_dig_en: got %h expected fe", dig_en); end
    n_tests++;
    if (seg !== 8'hC0) begin n_fail++; $display("FAIL reset_seg: got %h expected c0", seg); end
    set_read(32'hFFFFF020, 32'h0); check_read("reset_timer");
    set_read(32'hFFFFF000, 32'h0); check_read("reset_digits");
    cpu_rst = 1'b1;
    @(posedge cpu_clk); #1;
  endtask

  task automatic test_led;
    Bus_addr = 32'hFFFFF060; Bus_wdata = 32'h00ABCDEF; Bus_wen = 1'b1;
    #1;
    n_tests++;
    if (dram_wen !== 1'b0) begin n_fail++; $display("FAIL led_dram_wen: got %b expected 0", dram_wen); end
    @(posedge cpu_clk); #1;
    Bus_wen = 1'b0;
    n_tests++;
    if (led !== 24'hABCDEF) begin n_fail++; $display("FAIL led_out: got %h expected abcdef", led); end
    set_read(32'hFFFFF060, 32'h00ABCDEF); check_read("led_read");
    set_read(32'hFFFFF062, 32'h00ABCDEF); check_read("led_read_unaligned");
  endtask

  task automatic test_dram;
    Bus_addr = 32'h00000010; Bus_wdata = 32'h12345678; Bus_wen = 1'b1;
    #1;
    n_tests++;
    if (dram_wen !== 1'b1) begin n_fail++; $display("FAIL dram_wen_store: got %b expected 1", dram_wen); end
    n_tests++;
    if (dram_addr !== 14'd4) begin n_fail++; $display("FAIL dram_addr: got %0d expected 4", dram_addr); end
    @(posedge cpu_clk); #1;
    Bus_wen = 1'b0;
    #1;
    n_tests++;
    if (dram_wen !== 1'b0) begin n_fail++; $display("FAIL dram_wen_idle: got %b expected 0", dram_wen); end
    set_read(32'h00000010, 32'h12345678); check_read("dram_load");
    set_read(32'hFFFFF100, 32'h0); check_read("unmapped_read");
    @(posedge cpu_clk); #1;
    bus_write(32'hFFFFF070, 32'hFFFFFFFF);
    set_read(32'hFFFFF070, 32'h0); check_read("sw_ro_write");
    set_read(32'h00000010, 32'h12345678); check_read("dram_intact");
  endtask

  task automatic test_sync;
    sw = 24'h00F00F; button = 5'h15;
    set_read(32'hFFFFF070, 32'h0); check_read("sw_edge0");
    @(posedge cpu_clk); #1;
    set_read(32'hFFFFF070, 32'h0); check_read("sw_edge1");
    @(posedge cpu_clk); #1;
    set_read(32'hFFFFF070, 32'h0000F00F); check_read("sw_edge2");
    set_read(32'hFFFFF078, 32'h00000015); check_read("btn_edge2");
  endtask

  task automatic test_scan;
    logic [7:0] codes [0:7];
    logic [15:0] e;
    int k;
    codes[0] = 8'h80; codes[1] = 8'hF9; codes[2] = 8'hC0; codes[3] = 8'h88;
    codes[4] = 8'hC0; codes[5] = 8'hC0; codes[6] = 8'hC0; codes[7] = 8'hC0;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b1;
    bus_write(32'hFFFFF000, 32'h0000A018);
    for (int c = 1; c <= 36; c++) begin
      k = (c / 4) % 8;
      scan_q.push_back({~(8'b1 << k), codes[k]});
      e = scan_q.pop_front();
      n_tests++;
      if ({dig_en, seg} !== e) begin
        n_fail++;
        $display("FAIL scan_c%0d: dig_en/seg got %h/%h expected %h/%h", c, dig_en, seg, e[15:8], e[7:0]);
      end
      @(posedge cpu_clk); #1;
    end
  endtask

  task automatic test_timer;
    bus_write(32'hFFFFF020, 32'hFFFFFFFE);
    set_read(32'hFFFFF020, 32'hFFFFFFFE); check_read("timer_load");
    @(posedge cpu_clk); #1;
    set_read(32'hFFFFF020, 32'hFFFFFFFE); check_read("timer_presc1");
    @(posedge cpu_clk); #1;
    set_read(32'hFFFFF020, 32'hFFFFFFFF); check_read("timer_inc");
    repeat (2) @(posedge cpu_clk);
    #1;
    set_read(32'hFFFFF020, 32'h0); check_read("timer_wrap");
    @(posedge cpu_clk); #1;
    bus_write(32'hFFFFF020, 32'h55);
    set_read(32'hFFFFF020, 32'h55); check_read("timer_write_wins");
    @(posedge cpu_clk); #1;
    set_read(32'hFFFFF020, 32'h55); check_read("timer_after_write");
    @(posedge cpu_clk); #1;
    set_read(32'hFFFFF020, 32'h56); check_read("timer_next_inc");
  endtask

  task automatic test_reset_mid;
    bus_write(32'hFFFFF060, 32'h00FFFFFF);
    bus_write(32'hFFFFF020, 32'h100);
    bus_write(32'hFFFFF000, 32'h12345678);
    repeat (5) @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b0;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b1;
    n_tests++;
    if (led !== 24'h0) begin n_fail++; $display("FAIL mid_reset_led: got %h expected 000000", led); end
    n_tests++;
    if (dig_en !== 8'hFE) begin n_fail++; $display("FAIL mid_reset_dig_en: got %h expected fe", dig_en); end
    n_tests++;
    if (seg !== 8'hC0) begin n_fail++; $display("FAIL mid_reset_seg: got %h expected c0", seg); end
    set_read(32'hFFFFF020, 32'h0); check_read("mid_reset_timer");
    set_read(32'hFFFFF000, 32'h0); check_read("mid_reset_digits");
    repeat (3) @(posedge cpu_clk);
    #1;
    n_tests++;
    if (dig_en !== 8'hFE) begin n_fail++; $display("FAIL mid_reset_scan_hold: got %h expected fe", dig_en); end
    @(posedge cpu_clk); #1;
    n_tests++;
    if (dig_en !== 8'hFD) begin n_fail++; $display("FAIL mid_reset_scan_step: got %h expected fd", dig_en); end
  endtask

  initial begin
    cpu_rst = 1'b0; Bus_addr = '0; Bus_wen = 1'b0; Bus_wdata = '0; sw = '0; button = '0;
    test_reset;
    test_led;
    test_dram;
    test_sync;
    test_scan;
    test_timer;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
